// File: rtl/p3p_pkg.sv
// Shared types for the receive path: parity selection, UART FSM states,
// the project-wide number type, and the baud divider helper.
package p3p_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   typedef logic signed [15:0] num;

   // Clocks per bit, rounded to nearest.
   function automatic int clk_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; head valid 1 cycle after a push into empty.
// Push while full is accepted only alongside a pop; head holds the last popped word when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_dat_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     vld_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] hold_q;
   logic             empty, do_pop, do_push;

   assign empty   = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_dat_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop) begin
            rd_q   <= rd_q + 1'b1;
            hold_q <= mem[rd_q];
         end
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   assign head_o  = empty ? hold_q : mem[rd_q];
   assign vld_o   = ~empty;
   assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity) feeding a FWFT FIFO; push 1 cycle after stop sample, valid 1 later.
// Consumer stalls via m_ready; a good word arriving while full without a pop is dropped with an overrun pulse.
module uart_rx_fifo
   import p3p_pkg::*;
#(
   parameter int      CLK_HZ     = 50_000_000,
   parameter int      BAUD       = 115_200,
   parameter int      DATA_BITS  = 8,
   parameter parity_t PARITY     = PAR_NONE,
   parameter int      FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun
);

   localparam int DIV = clk_div(CLK_HZ, BAUD);
   localparam int TW  = $clog2(DIV);
   localparam int IW  = $clog2(DATA_BITS);

   uart_state_t          state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 pmis_q, pmis_d;
   logic                 push_q, push_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 ovr_q;
   logic                 rx_meta_q, rx_s_q, rx_prev_q;
   logic                 mid, par_exp, fifo_full;

   assign mid     = (timer_q == '0);
   assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pmis_d  = pmis_q;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      if (state_q != IDLE && state_q != BREAK)
         timer_d = mid ? TW'(DIV - 1) : timer_q - 1'b1;
      case (state_q)
         IDLE: if (rx_prev_q && !rx_s_q) begin
            timer_d = TW'(DIV / 2 - 1);
            state_d = START;
         end
         START: if (mid) begin
            state_d = rx_s_q ? IDLE : DATA;
            idx_d   = '0;
            pmis_d  = 1'b0;
         end
         DATA: if (mid) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (idx_q == IW'(DATA_BITS - 1))
               state_d = (PARITY != PAR_NONE) ? p3p_pkg::PARITY : STOP;
            else
               idx_d = idx_q + 1'b1;
         end
         p3p_pkg::PARITY: if (mid) begin
            pmis_d  = (rx_s_q != par_exp);
            state_d = STOP;
         end
         STOP: if (mid) begin
            if (!rx_s_q) begin
               ferr_d  = 1'b1;
               state_d = BREAK;
            end else begin
               perr_d  = pmis_q;
               push_d  = ~pmis_q;
               state_d = IDLE;
            end
         end
         BREAK: if (rx_s_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         pmis_q    <= 1'b0;
         push_q    <= 1'b0;
         ferr_q    <= 1'b0;
         perr_q    <= 1'b0;
         ovr_q     <= 1'b0;
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         pmis_q    <= pmis_d;
         push_q    <= push_d;
         ferr_q    <= ferr_d;
         perr_q    <= perr_d;
         ovr_q     <= push_q & fifo_full & ~m_ready;
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // shift_q is stable while push_q is high: IDLE never touches it.
   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push_q),
      .push_dat_i (shift_q),
      .pop_i      (m_ready),
      .head_o     (m_data),
      .vld_o      (m_valid),
      .full_o     (fifo_full),
      .count_o    (fifo_count)
   );

   assign frame_err  = ferr_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8N1 instance plus an even-parity instance, scoreboard-checked.
module tb_uart_rx_fifo;
   import p3p_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1, rx_p = 1'b1;
   logic       m_ready = 1'b1, m_ready_p = 1'b1;
   logic [7:0] m_data, m_data_p;
   logic       m_valid, m_valid_p;
   logic [4:0] fifo_count, fifo_count_p;
   logic       frame_err, parity_err, overrun;
   logic       frame_err_p, parity_err_p, overrun_p;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .FIFO_DEPTH(16)) dut (
      .clk(clk), .reset(reset), .rx(rx), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .fifo_count(fifo_count), .frame_err(frame_err),
      .parity_err(parity_err), .overrun(overrun));

   uart_rx_fifo #(.CLK_HZ(100_000_000), .BAUD(1_000_000), .DATA_BITS(8),
                  .PARITY(PAR_EVEN), .FIFO_DEPTH(16)) dut_p (
      .clk(clk), .reset(reset), .rx(rx_p), .m_data(m_data_p), .m_valid(m_valid_p),
      .m_ready(m_ready_p), .fifo_count(fifo_count_p), .frame_err(frame_err_p),
      .parity_err(parity_err_p), .overrun(overrun_p));

   int total = 0, bad = 0;
   int cyc = 0, start_cyc = 0, rise_cyc = -1;
   int n_ferr = 0, n_perr = 0, n_ovr = 0, n_words = 0, n_vld = 0;
   int n_ferr_p = 0, n_perr_p = 0, n_words_p = 0;
   logic prev_vld = 1'b0;
   logic [7:0] exp_q[$], exp_qp[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset) begin
         if (m_valid && !prev_vld) rise_cyc = cyc;
         prev_vld = m_valid;
         if (m_valid) n_vld++;
         if (m_valid && m_ready) begin
            n_words++;
            if (exp_q.size() == 0) chk("unexpected_word", int'(m_data), -1);
            else begin e = exp_q.pop_front(); chk("word", int'(m_data), int'(e)); end
         end
         if (m_valid_p && m_ready_p) begin
            n_words_p++;
            if (exp_qp.size() == 0) chk("unexpected_word_p", int'(m_data_p), -1);
            else begin e = exp_qp.pop_front(); chk("word_p", int'(m_data_p), int'(e)); end
         end
         if (frame_err)    n_ferr++;
         if (parity_err)   n_perr++;
         if (overrun)      n_ovr++;
         if (frame_err_p)  n_ferr_p++;
         if (parity_err_p) n_perr_p++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input bit sel, input logic v);
      if (sel) rx_p = v; else rx = v;
   endtask

   // par < 0 means no parity bit; the stop level is held for 100+tail clocks.
   task automatic send(input bit sel, input logic [7:0] d, input int par,
                       input logic stop_bit, input int tail);
      set_line(sel, 1'b0);
      start_cyc = cyc;
      tick(100);
      for (int i = 0; i < 8; i++) begin
         set_line(sel, d[i]);
         tick(100);
      end
      if (par >= 0) begin
         set_line(sel, par[0]);
         tick(100);
      end
      set_line(sel, stop_bit);
      tick(100 + tail);
      set_line(sel, 1'b1);
   endtask

   typedef struct {
      logic [7:0] dat;
      logic       stop_bit;
      int         exp_words;
      int         exp_ferr;
   } vec_t;

   vec_t vecs[6];
   int f0, p0, o0, w0, v0;

   task automatic snap();
      f0 = n_ferr; p0 = n_perr; o0 = n_ovr; w0 = n_words; v0 = n_vld;
   endtask

   initial begin
      vecs[0] = '{8'h00, 1'b1, 1, 0};
      vecs[1] = '{8'hFF, 1'b1, 1, 0};
      vecs[2] = '{8'hA5, 1'b1, 1, 0};
      vecs[3] = '{8'h5A, 1'b0, 0, 1};
      vecs[4] = '{8'h3C, 1'b1, 1, 0};
      vecs[5] = '{8'h81, 1'b1, 1, 0};

      tick(5);
      reset = 1'b0;
      tick(3);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_errs", int'({frame_err, parity_err, overrun}), 0);

      // 1: single 8N1 frame, latency and one-cycle valid
      snap();
      rise_cyc = -1;
      exp_q.push_back(8'h55);
      send(1'b0, 8'h55, -1, 1'b1, 0);
      tick(50);
      if (rise_cyc - start_cyc < 953 || rise_cyc - start_cyc > 956) begin
         total++; bad++;
         $display("FAIL t1_latency: got %0d want 953..956", rise_cyc - start_cyc);
      end else total++;
      chk("t1_words", n_words - w0, 1);
      chk("t1_vld_cycles", n_vld - v0, 1);
      chk("t1_errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);

      // 2: 30-clock glitch is rejected silently
      snap();
      rx = 1'b0; tick(30); rx = 1'b1; tick(300);
      chk("t2_words", n_words - w0, 0);
      chk("t2_errs", (n_ferr - f0) + (n_perr - p0), 0);
      chk("t2_count", int'(fifo_count), 0);

      // table-driven frames, consumer always ready
      for (int k = 0; k < 6; k++) begin
         snap();
         if (vecs[k].exp_words != 0) exp_q.push_back(vecs[k].dat);
         send(1'b0, vecs[k].dat, -1, vecs[k].stop_bit, 0);
         tick(60);
         chk($sformatf("vec%0d_ferr", k), n_ferr - f0, vecs[k].exp_ferr);
         chk($sformatf("vec%0d_words", k), n_words - w0, vecs[k].exp_words);
         chk($sformatf("vec%0d_perr", k), n_perr - p0, 0);
      end

      // 3: bad stop then long break -> one frame_err, then recovery
      snap();
      send(1'b0, 8'hA3, -1, 1'b0, 1900);
      tick(50);
      chk("t3_ferr", n_ferr - f0, 1);
      chk("t3_count", int'(fifo_count), 0);
      chk("t3_words", n_words - w0, 0);
      exp_q.push_back(8'h3C);
      send(1'b0, 8'h3C, -1, 1'b1, 0);
      tick(50);
      chk("t3_recover", n_words - w0, 1);

      // 4: fill past capacity with consumer stalled
      snap();
      m_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) exp_q.push_back(i[7:0]);
         send(1'b0, i[7:0], -1, 1'b1, 20);
      end
      tick(10);
      chk("t4_count_full", int'(fifo_count), 16);
      chk("t4_overrun", n_ovr - o0, 1);
      chk("t4_head", int'(m_data), 0);
      chk("t4_valid", int'(m_valid), 1);
      m_ready = 1'b1;
      tick(30);
      chk("t4_drained", n_words - w0, 16);
      chk("t4_count_empty", int'(fifo_count), 0);
      chk("t4_valid_low", int'(m_valid), 0);
      chk("t4_hold_last", int'(m_data), 8'h0F);
      chk("t4_scoreboard", exp_q.size(), 0);

      // 5: even parity instance
      send(1'b1, 8'h07, 0, 1'b1, 20);
      tick(30);
      chk("t5_perr", n_perr_p, 1);
      chk("t5_dropped", n_words_p, 0);
      exp_qp.push_back(8'h07);
      send(1'b1, 8'h07, 1, 1'b1, 20);
      tick(30);
      chk("t5_words", n_words_p, 1);
      chk("t5_perr_once", n_perr_p, 1);
      chk("t5_ferr", n_ferr_p, 0);

      // 6: reset pulse during data bit 4 of 0xFF
      snap();
      rx = 1'b0; tick(100);
      rx = 1'b1; tick(450);
      reset = 1'b1; tick(1); reset = 1'b0;
      tick(450);
      tick(50);
      chk("t6_valid", int'(m_valid), 0);
      chk("t6_count", int'(fifo_count), 0);
      chk("t6_errs", (n_ferr - f0) + (n_perr - p0) + (n_ovr - o0), 0);
      chk("t6_words", n_words - w0, 0);
      exp_q.push_back(8'h81);
      send(1'b0, 8'h81, -1, 1'b1, 0);
      tick(50);
      chk("t6_recover", n_words - w0, 1);
      chk("t6_scoreboard", exp_q.size() + exp_qp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
